garbage_receiver: RTL and testbench
===================================

Name: garbage_receiver

Overview:
- Receiving end of the attack path. Accepts garbage batches sent by the opponent and queues them with a random hole column per batch.
- On each piece lock, either cancels queued garbage against this player's outgoing attack, or inserts queued garbage rows into the playfield.
- Forwards any attack left after cancellation to the opponent. Sits between the link/opponent interface, the line-clear scoring logic and the playfield row-insert logic.

Parameters:
- QUEUE_DEPTH, 8, number of pending garbage batches held.
- MAX_INSERT, 8, maximum rows inserted per lock.
- CNT_W, 5, width of all per-batch and attack line counts.

Ports:
- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- game_start  in  1  synchronous clear of queue and FSM
- recv_valid  in  1  one-cycle pulse: a garbage batch has arrived
- recv_lines  in  CNT_W  lines in the arriving batch
- recv_dropped  out  1  one-cycle pulse: batch discarded because queue full
- falling_piece_lock  in  1  one-cycle pulse on piece lock
- lock_cleared  in  1  the lock cleared at least one line (valid with lock)
- attack_lines  in  CNT_W  outgoing attack of this lock (valid with lock)
- send_valid  out  1  one-cycle pulse: net attack to opponent
- send_lines  out  CNT_W  net attack lines; 0 when send_valid low
- insert_valid  out  1  garbage insert request to playfield
- insert_ready  in  1  playfield accepts request this cycle
- insert_rows  out  CNT_W  rows to insert, 1..MAX_INSERT
- insert_hole  out  4  hole column, 0..PLAYFIELD_COLS-1
- pending_total  out  8  sum of lines across all queued batches
- queue_full  out  1  queue holds QUEUE_DEPTH entries
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_l low): queue empty, FSM IDLE, LFSR = 16'hACE1, all outputs 0.
- game_start: same clear as reset except the LFSR is not reseeded. game_start has priority over every other input in the same cycle, aborts any operation in flight, and asserts no pulses.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle.
- Enqueue: a recv_valid with recv_lines != 0 writes {lines, hole = lfsr[3:0] mod PLAYFIELD_COLS} at the tail in the same cycle.
  - Zero-line batches are ignored.
  - If queue_full (registered value), the batch is dropped and recv_dropped pulses the next cycle.
  - Enqueue is legal in every FSM state, including concurrently with a head update or pop.
- pending_total, registered: next = current + enqueued lines − lines removed this cycle. It never wraps (max 31*8 = 248).
- FSM states: IDLE, CANCEL, SEND, INSERT.
- IDLE, on falling_piece_lock:
  - If lock_cleared and attack_lines != 0: go to CANCEL with att_rem = attack_lines.
  - If lock_cleared and attack_lines = 0: stay in IDLE.
  - If !lock_cleared: go to INSERT with budget = MAX_INSERT.
- A lock pulse while busy is ignored; the driver must guarantee this does not happen.
- CANCEL, one step per cycle:
  - Queue empty: go to SEND.
  - head.lines <= att_rem: pop the head, att_rem -= head.lines. If the result is 0, go to IDLE.
  - Otherwise: head.lines -= att_rem, att_rem = 0, go to IDLE.
- SEND: send_valid = 1 and send_lines = att_rem for exactly one cycle, then go to IDLE. No pulse is ever sent when att_rem = 0.
- INSERT:
  - If queue empty or budget = 0: go to IDLE with no request.
  - Otherwise drive insert_valid = 1, insert_rows = min(head.lines, budget), insert_hole = head.hole.
  - Outputs are held stable until insert_ready.
  - On handshake: budget -= insert_rows; head.lines -= insert_rows, popping the head if it reaches 0. Stay in INSERT.
  - Batches keep their own hole column; a partially inserted batch keeps its hole for the remainder.
- insert_valid is combinationally decoded from registered state and queue head only. It never depends on insert_ready.
- Send and insert latencies:
  - Send pulse: N+2 cycles after the lock, where N = number of batches consumed.
  - First insert request: asserted the cycle after the lock.

Decomposition:
- DisplayPkg: PLAYFIELD_COLS, and typedef garbage_entry_t {logic [CNT_W-1:0] lines; logic [3:0] hole;}.
- One natural sub-module: garbage_fifo, a circular queue of garbage_entry_t.
  - Ports: push, pop, head-update write port, head, count, full, empty.
  - Head update and pop are mutually exclusive per cycle; either may coincide with push.
- The LFSR and FSM live in garbage_receiver.

Test Plan:
- Receive 3 then 2, then lock with lock_cleared = 0 → one request {rows 3, hole h0}, then {rows 2, hole h1}; pending_total goes 5 → 2 → 0; busy drops after an empty check.
- Queue {4}, then lock with lock_cleared = 1, attack 6 → head popped, send_valid pulses with send_lines = 2 on cycle lock+3, pending_total = 0.
- Queue {4}, then lock with lock_cleared = 1, attack 1 → head becomes 3, no send_valid, pending_total = 3.
- Queue a batch of 10, then lock with lock_cleared = 0 and insert_ready held low for 5 cycles → insert_valid stays 1 with rows = 8 stable. After the handshake, head = 2 remains, same hole, and the FSM returns to IDLE.
- Fill 8 batches, then recv_valid with 3 → recv_dropped pulses, pending_total unchanged. recv_valid in the same cycle as an INSERT pop while full is still dropped.
- game_start asserted mid-INSERT with 3 batches queued → next cycle insert_valid = 0, pending_total = 0, busy = 0, queue_full = 0.

Source files
------------

// File: rtl/garbage_receiver_pkg.sv
// Shared types for the garbage receive path: queue entry, FSM states,
// playfield width and hole-column helper.
package garbage_receiver_pkg;
  localparam int CNT_W = 5;
  localparam int PLAYFIELD_COLS = 10;

  typedef struct packed {
    logic [CNT_W-1:0] lines;
    logic [3:0]       hole;
  } garbage_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    CANCEL,
    SEND,
    INSERT
  } rx_state_e;

  function automatic logic [3:0] hole_of(input logic [3:0] v);
    return (v >= 4'(PLAYFIELD_COLS)) ? v - 4'(PLAYFIELD_COLS) : v;
  endfunction
endpackage

// File: rtl/garbage_fifo.sv
// Circular queue of pending garbage batches with an in-place head update.
module garbage_fifo
  import garbage_receiver_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             clear,
  input  logic             push,
  input  garbage_entry_t   push_data,
  input  logic             pop,
  input  logic             upd,
  input  logic [CNT_W-1:0] upd_lines,
  output garbage_entry_t   head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  garbage_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (upd && !empty && !clear) mem[rd_ptr].lines <= upd_lines;
  end
endmodule

// File: rtl/garbage_receiver.sv
// Queues incoming garbage, cancels it against outgoing attacks and
// feeds remaining rows to the playfield on each piece lock.
module garbage_receiver
  import garbage_receiver_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int MAX_INSERT  = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             game_start,
  input  logic             recv_valid,
  input  logic [CNT_W-1:0] recv_lines,
  output logic             recv_dropped,
  input  logic             falling_piece_lock,
  input  logic             lock_cleared,
  input  logic [CNT_W-1:0] attack_lines,
  output logic             send_valid,
  output logic [CNT_W-1:0] send_lines,
  output logic             insert_valid,
  input  logic             insert_ready,
  output logic [CNT_W-1:0] insert_rows,
  output logic [3:0]       insert_hole,
  output logic [7:0]       pending_total,
  output logic             queue_full,
  output logic             busy
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  rx_state_e state, state_n;
  logic [15:0] lfsr;
  logic [CNT_W-1:0] att_rem, att_n;
  logic [CNT_W-1:0] budget, budget_n;
  logic [CNT_W-1:0] removed;
  logic [CNT_W-1:0] upd_lines;
  logic pop, upd, push, enq;
  garbage_entry_t head;
  logic [CW-1:0] q_count;
  logic q_full, q_empty;

  assign push = recv_valid && recv_lines != '0 && !game_start;
  assign enq  = push && q_count < CW'(QUEUE_DEPTH);
  assign queue_full = q_full;
  assign busy = state != IDLE;

  garbage_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .clear     (game_start),
    .push      (push),
    .push_data ({recv_lines, hole_of(lfsr[3:0])}),
    .pop       (pop),
    .upd       (upd),
    .upd_lines (upd_lines),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lfsr          <= 16'hACE1;
      state         <= IDLE;
      att_rem       <= '0;
      budget        <= '0;
      pending_total <= '0;
      recv_dropped  <= 1'b0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (game_start) begin
        state         <= IDLE;
        att_rem       <= '0;
        budget        <= '0;
        pending_total <= '0;
        recv_dropped  <= 1'b0;
      end else begin
        state         <= state_n;
        att_rem       <= att_n;
        budget        <= budget_n;
        pending_total <= pending_total + (enq ? 8'(recv_lines) : 8'd0)
                         - 8'(removed);
        recv_dropped  <= push && q_full;
      end
    end
  end

  always_comb begin
    state_n      = state;
    att_n        = att_rem;
    budget_n     = budget;
    pop          = 1'b0;
    upd          = 1'b0;
    upd_lines    = head.lines;
    removed      = '0;
    send_valid   = 1'b0;
    send_lines   = '0;
    insert_valid = 1'b0;
    insert_rows  = '0;
    insert_hole  = '0;
    unique case (state)
      IDLE: begin
        if (falling_piece_lock) begin
          if (!lock_cleared) begin
            state_n  = INSERT;
            budget_n = CNT_W'(MAX_INSERT);
          end else if (attack_lines != '0) begin
            state_n = CANCEL;
            att_n   = attack_lines;
          end
        end
      end
      CANCEL: begin
        if (q_empty) begin
          state_n = SEND;
        end else if (head.lines <= att_rem) begin
          pop     = 1'b1;
          removed = head.lines;
          att_n   = att_rem - head.lines;
          if (att_n == '0) state_n = IDLE;
        end else begin
          upd       = 1'b1;
          upd_lines = head.lines - att_rem;
          removed   = att_rem;
          att_n     = '0;
          state_n   = IDLE;
        end
      end
      SEND: begin
        send_valid = !game_start;
        send_lines = game_start ? '0 : att_rem;
        state_n    = IDLE;
      end
      INSERT: begin
        if (q_empty || budget == '0) begin
          state_n = IDLE;
        end else begin
          insert_valid = 1'b1;
          insert_rows  = (head.lines < budget) ? head.lines : budget;
          insert_hole  = head.hole;
          if (insert_ready) begin
            budget_n = budget - insert_rows;
            removed  = insert_rows;
            if (insert_rows == head.lines) begin
              pop = 1'b1;
            end else begin
              upd       = 1'b1;
              upd_lines = head.lines - insert_rows;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_garbage_receiver.sv
// Directed and randomized checks of garbage_receiver against a
// transaction-level queue model.
module tb_garbage_receiver;
  logic       clk = 0;
  logic       rst_l = 0;
  logic       game_start = 0;
  logic       recv_valid = 0;
  logic [4:0] recv_lines = 0;
  logic       recv_dropped;
  logic       falling_piece_lock = 0;
  logic       lock_cleared = 0;
  logic [4:0] attack_lines = 0;
  logic       send_valid;
  logic [4:0] send_lines;
  logic       insert_valid;
  logic       insert_ready = 0;
  logic [4:0] insert_rows;
  logic [3:0] insert_hole;
  logic [7:0] pending_total;
  logic       queue_full;
  logic       busy;

  garbage_receiver dut (
    .clk(clk), .rst_l(rst_l), .game_start(game_start),
    .recv_valid(recv_valid), .recv_lines(recv_lines),
    .recv_dropped(recv_dropped),
    .falling_piece_lock(falling_piece_lock),
    .lock_cleared(lock_cleared), .attack_lines(attack_lines),
    .send_valid(send_valid), .send_lines(send_lines),
    .insert_valid(insert_valid), .insert_ready(insert_ready),
    .insert_rows(insert_rows), .insert_hole(insert_hole),
    .pending_total(pending_total), .queue_full(queue_full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int c;
  } ev_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int drop_exp = 0;
  int first_req = -1;
  int done_cyc = 0;
  ev_t q[$];
  ev_t ins_log[$];
  ev_t send_log[$];
  logic hold_chk = 0;
  int hold_rows = 0;
  int hold_hole = 0;
  logic [15:0] lfsr_m;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  always @(posedge clk or negedge rst_l)
    if (!rst_l) lfsr_m <= 16'hACE1;
    else lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5],
                    lfsr_m[15:1]};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int q_sum();
    int s = 0;
    foreach (q[i]) s += q[i].a;
    return s;
  endfunction

  task automatic step();
    if (hold_chk) begin
      chk("hold_valid", int'(insert_valid), 1);
      chk("hold_rows", int'(insert_rows), hold_rows);
      chk("hold_hole", int'(insert_hole), hold_hole);
    end
    hold_chk  = insert_valid && !insert_ready && !game_start;
    hold_rows = int'(insert_rows);
    hold_hole = int'(insert_hole);
    if (insert_valid && first_req < 0) first_req = cyc;
    if (insert_valid && insert_ready)
      ins_log.push_back('{int'(insert_rows), int'(insert_hole), cyc});
    if (send_valid) send_log.push_back('{int'(send_lines), 0, cyc});
    if (recv_dropped) drop_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic recv(input int l);
    recv_valid = 1;
    recv_lines = 5'(l);
    if (l != 0) begin
      if (q.size() < 8) q.push_back('{l, int'(lfsr_m[3:0]) % 10, 0});
      else drop_exp++;
    end
    step();
    recv_valid = 0;
    recv_lines = 0;
  endtask

  // mode: 0 random ready, 1 ready high, 2 ready low for 5 cycles
  task automatic lock(input int clr, input int att, input int mode,
                      input int extra);
    ev_t exp_ins[$];
    int rem, n, budget, r, c0, send_exp, done;
    rem = att;
    n = 0;
    send_exp = 0;
    if (clr != 0) begin
      if (att != 0) begin
        while (q.size() > 0) begin
          if (q[0].a <= rem) begin
            rem -= q[0].a;
            void'(q.pop_front());
            n++;
            if (rem == 0) break;
          end else begin
            q[0].a -= rem;
            rem = 0;
            break;
          end
        end
        send_exp = rem;
      end
    end else begin
      budget = 8;
      while (q.size() > 0 && budget > 0) begin
        r = (q[0].a < budget) ? q[0].a : budget;
        exp_ins.push_back('{r, q[0].b, 0});
        budget -= r;
        q[0].a -= r;
        if (q[0].a == 0) void'(q.pop_front());
      end
    end
    ins_log.delete();
    send_log.delete();
    first_req = -1;
    c0 = cyc;
    falling_piece_lock = 1;
    lock_cleared = 1'(clr);
    attack_lines = 5'(att);
    insert_ready = 0;
    step();
    falling_piece_lock = 0;
    lock_cleared = 0;
    attack_lines = 0;
    done = 0;
    for (int k = 0; k < 100 && done == 0; k++) begin
      if (mode == 1) insert_ready = 1;
      else if (mode == 2) insert_ready = (k >= 5);
      else insert_ready = 1'($urandom % 2);
      if (k == 0 && extra != 0) begin
        recv_valid = 1;
        recv_lines = 5'(extra);
        drop_exp++;
      end
      step();
      recv_valid = 0;
      recv_lines = 0;
      if (!busy) done = 1;
    end
    insert_ready = 0;
    done_cyc = cyc;
    chk("lock_timeout", done, 1);
    chk("ins_count", ins_log.size(), exp_ins.size());
    for (int i = 0; i < exp_ins.size() && i < ins_log.size(); i++) begin
      chk("ins_rows", ins_log[i].a, exp_ins[i].a);
      chk("ins_hole", ins_log[i].b, exp_ins[i].b);
    end
    if (exp_ins.size() > 0) chk("first_req_cyc", first_req, c0 + 1);
    chk("send_count", send_log.size(), send_exp != 0 ? 1 : 0);
    if (send_exp != 0 && send_log.size() > 0) begin
      chk("send_lines", send_log[0].a, send_exp);
      chk("send_cyc", send_log[0].c, c0 + n + 2);
    end
    chk("pending", int'(pending_total), q_sum());
    chk("queue_full", int'(queue_full), q.size() == 8 ? 1 : 0);
    chk("drops", drop_cnt, drop_exp);
  endtask

  initial begin
    int c0, nb, nl;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending", int'(pending_total), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(queue_full), 0);
    chk("rst_insv", int'(insert_valid), 0);
    chk("rst_send", int'(send_valid), 0);
    chk("rst_drop", int'(recv_dropped), 0);
    rst_l = 1;
    step();

    // Two batches inserted in order with their own holes.
    recv(3);
    recv(2);
    chk("pend_5", int'(pending_total), 5);
    c0 = cyc;
    lock(0, 0, 1, 0);
    chk("insert_idle_cyc", done_cyc, c0 + 4);

    // Attack exceeds queue: leftover is sent.
    recv(4);
    lock(1, 6, 1, 0);

    // Partial cancel keeps remainder queued, nothing sent.
    recv(4);
    lock(1, 1, 1, 0);
    lock(0, 0, 1, 0);

    // Large batch stalls on ready, then split across locks.
    recv(10);
    lock(0, 0, 2, 0);
    chk("split_rem", int'(pending_total), 2);
    lock(0, 0, 1, 0);

    // Full queue drops, including alongside an insert pop.
    for (int i = 1; i <= 8; i++) recv(i);
    chk("fill_full", int'(queue_full), 1);
    recv(3);
    step();
    chk("drop_pend", int'(pending_total), 36);
    chk("drop_cnt", drop_cnt, drop_exp);
    lock(0, 0, 1, 3);
    while (q.size() > 0) lock(0, 0, 1, 0);

    // game_start aborts an in-flight insert and clears the queue.
    recv(3);
    recv(4);
    recv(5);
    falling_piece_lock = 1;
    step();
    falling_piece_lock = 0;
    step();
    step();
    chk("gs_pre_valid", int'(insert_valid), 1);
    game_start = 1;
    step();
    game_start = 0;
    q.delete();
    chk("gs_insv", int'(insert_valid), 0);
    chk("gs_pend", int'(pending_total), 0);
    chk("gs_busy", int'(busy), 0);
    chk("gs_full", int'(queue_full), 0);
    chk("gs_drop", int'(recv_dropped), 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      nb = $urandom_range(0, 4);
      for (int j = 0; j < nb; j++) begin
        nl = $urandom_range(0, 31);
        recv(nl);
      end
      lock($urandom % 2, $urandom_range(0, 31), $urandom % 2, 0);
    end
    step();
    chk("final_drops", drop_cnt, drop_exp);
    chk("final_pend", int'(pending_total), q_sum());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
